// File: rtl/text_video_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : text_video_sequencer
// Purpose  : Raster timing and text-RAM fetch sequencer feeding the character
//            generator, with delayed sync/blank/border qualifiers.
// Revision : 1.0 - initial release
// ============================================================================
module text_video_sequencer #(
    parameter int H_ACTIVE   = 512,
    parameter int H_BORDER_R = 64,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int H_BORDER_L = 64,
    parameter int ROW_LINES  = 24,
    parameter int V_BORDER_B = 48,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int V_BORDER_T = 48,
    parameter int PIX_DELAY  = 6
) (
    input  logic       reset,
    input  logic       pixel_clock,
    input  logic       width_64,
    input  logic [7:0] vram_data,
    output logic [9:0] vram_addr,
    output logic       vram_rd,
    output logic [7:0] char_code,
    output logic [4:0] subchar_line,
    output logic [3:0] subchar_pixel,
    output logic       text_active,
    output logic       de_out,
    output logic       border_out,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_BORDER_R + H_FP + H_SYNC + H_BP + H_BORDER_L;
    localparam int c_V_TEXT  = ROW_LINES * 16;
    localparam int c_V_TOTAL = c_V_TEXT + V_BORDER_B + V_FP + V_SYNC + V_BP + V_BORDER_T;

    localparam logic [9:0] c_H_LAST       = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_H_TEXT_END   = 10'(H_ACTIVE);
    localparam logic [9:0] c_H_VIS_END    = 10'(H_ACTIVE + H_BORDER_R);
    localparam logic [9:0] c_H_SYNC_BEG   = 10'(H_ACTIVE + H_BORDER_R + H_FP);
    localparam logic [9:0] c_H_SYNC_END   = 10'(H_ACTIVE + H_BORDER_R + H_FP + H_SYNC);
    localparam logic [9:0] c_H_BORDL_BEG  = 10'(H_ACTIVE + H_BORDER_R + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] c_V_LAST       = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_V_TEXT_END   = 10'(c_V_TEXT);
    localparam logic [9:0] c_V_VIS_END    = 10'(c_V_TEXT + V_BORDER_B);
    localparam logic [9:0] c_V_SYNC_BEG   = 10'(c_V_TEXT + V_BORDER_B + V_FP);
    localparam logic [9:0] c_V_SYNC_END   = 10'(c_V_TEXT + V_BORDER_B + V_FP + V_SYNC);
    localparam logic [9:0] c_V_BORDT_BEG  = 10'(c_V_TEXT + V_BORDER_B + V_FP + V_SYNC + V_BP);
    localparam logic [4:0] c_ROW_LAST     = 5'(ROW_LINES - 1);

    logic [9:0] r_h_count;
    logic [9:0] r_v_count;
    logic [3:0] r_row;
    logic [4:0] r_subline;
    logic       r_m64;
    logic       r_border;
    logic       r_hsync;
    logic       r_vsync;
    logic [3:0] r_dly [PIX_DELAY];

    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_frame;
    logic       w_text;
    logic       w_visible;
    logic       w_hsync;
    logic       w_vsync;
    logic [3:0] w_pix;
    logic [5:0] w_col;
    logic [9:0] w_addr;

    assign w_h_wrap  = (r_h_count == c_H_LAST);
    assign w_v_wrap  = (r_v_count == c_V_LAST);
    assign w_frame   = (r_h_count == 10'd0) && (r_v_count == 10'd0);
    assign w_text    = (r_h_count < c_H_TEXT_END) && (r_v_count < c_V_TEXT_END);
    assign w_visible = ((r_h_count < c_H_VIS_END) || (r_h_count >= c_H_BORDL_BEG)) &&
                       ((r_v_count < c_V_VIS_END) || (r_v_count >= c_V_BORDT_BEG));
    assign w_hsync   = (r_h_count >= c_H_SYNC_BEG) && (r_h_count < c_H_SYNC_END);
    assign w_vsync   = (r_v_count >= c_V_SYNC_BEG) && (r_v_count < c_V_SYNC_END);
    assign w_pix     = r_m64 ? {1'b0, r_h_count[2:0]} : r_h_count[3:0];
    assign w_col     = r_m64 ? r_h_count[8:3] : {1'b0, r_h_count[8:4]};
    assign w_addr    = r_m64 ? {r_row, w_col} : {1'b0, r_row, w_col[4:0]};

    // Row and sub-line advance with v_count so no divider is needed.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
            r_row     <= '0;
            r_subline <= '0;
            r_m64     <= 1'b0;
        end else begin
            if (w_h_wrap) begin
                r_h_count <= '0;
                if (w_v_wrap) begin
                    r_v_count <= '0;
                    r_row     <= '0;
                    r_subline <= '0;
                end else begin
                    r_v_count <= r_v_count + 10'd1;
                    if (r_subline == c_ROW_LAST) begin
                        r_subline <= '0;
                        r_row     <= r_row + 4'd1;
                    end else begin
                        r_subline <= r_subline + 5'd1;
                    end
                end
            end else begin
                r_h_count <= r_h_count + 10'd1;
            end
            if (w_frame) begin
                r_m64 <= width_64;
            end
        end
    end

    // RAM data arrives the clock after vram_rd, i.e. while subchar_pixel is 2.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            vram_addr     <= '0;
            vram_rd       <= 1'b0;
            char_code     <= '0;
            subchar_line  <= '0;
            subchar_pixel <= '0;
            text_active   <= 1'b0;
            frame_start   <= 1'b0;
            r_border      <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
        end else begin
            vram_addr     <= w_addr;
            vram_rd       <= w_text && (w_pix == 4'd1);
            subchar_line  <= r_subline;
            subchar_pixel <= w_pix;
            text_active   <= w_text;
            frame_start   <= w_frame;
            r_border      <= w_visible && !w_text;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            if (!w_text) begin
                char_code <= 8'h20;
            end else if (text_active && (subchar_pixel == 4'd2)) begin
                char_code <= vram_data;
            end
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIX_DELAY; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= {text_active, r_border, r_hsync, r_vsync};
            for (int i = 1; i < PIX_DELAY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign de_out     = r_dly[PIX_DELAY-1][3];
    assign border_out = r_dly[PIX_DELAY-1][2];
    assign hsync_n    = ~r_dly[PIX_DELAY-1][1];
    assign vsync_n    = ~r_dly[PIX_DELAY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_text_video_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_video_sequencer
// Purpose  : Self-checking bench for text_video_sequencer (short vertical frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_video_sequencer;

    localparam int c_RL        = 2;
    localparam int c_H_TOTAL   = 800;
    localparam int c_V_TEXT    = 16 * c_RL;
    localparam int c_V_TOTAL   = c_V_TEXT + 2 + 1 + 2 + 1 + 2;
    localparam int c_PIX_DELAY = 6;

    logic       reset;
    logic       pixel_clock;
    logic       width_64;
    logic [7:0] vram_data;
    logic [9:0] vram_addr;
    logic       vram_rd;
    logic [7:0] char_code;
    logic [4:0] subchar_line;
    logic [3:0] subchar_pixel;
    logic       text_active;
    logic       de_out;
    logic       border_out;
    logic       hsync_n;
    logic       vsync_n;
    logic       frame_start;

    text_video_sequencer #(
        .ROW_LINES (c_RL),
        .V_BORDER_B(2),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (1),
        .V_BORDER_T(2)
    ) dut (
        .reset        (reset),
        .pixel_clock  (pixel_clock),
        .width_64     (width_64),
        .vram_data    (vram_data),
        .vram_addr    (vram_addr),
        .vram_rd      (vram_rd),
        .char_code    (char_code),
        .subchar_line (subchar_line),
        .subchar_pixel(subchar_pixel),
        .text_active  (text_active),
        .de_out       (de_out),
        .border_out   (border_out),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .frame_start  (frame_start)
    );

    initial pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    int         tests = 0;
    int         fails = 0;
    int         p = -1;
    logic       model_m64 = 1'b0;
    logic [7:0] exp_char = 8'h00;
    logic [7:0] pending = 8'hEE;
    logic [7:0] mem [1024];
    int         cnt_rd, cnt_de, cnt_hs, cnt_vs, cnt_pix3;

    function automatic int h_of(input int q);
        return q % c_H_TOTAL;
    endfunction

    function automatic int v_of(input int q);
        return (q / c_H_TOTAL) % c_V_TOTAL;
    endfunction

    // {text, border, hsync, vsync} at raster position q; nothing before the first position
    function automatic logic [3:0] flags_of(input int q);
        int   h, v;
        logic t, vis;
        if (q < 0) return 4'b0000;
        h   = h_of(q);
        v   = v_of(q);
        t   = (h < 512) && (v < c_V_TEXT);
        vis = (h < 576 || h >= 736) && (v < c_V_TEXT + 2 || v >= c_V_TOTAL - 2);
        return {t, vis && !t, (h >= 592 && h < 688), (v >= c_V_TEXT + 3 && v < c_V_TEXT + 5)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_rd = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_pix3 = 0;
    endtask

    task automatic step();
        int         h, v, pix, col, row, addr;
        logic [3:0] f, fd;
        logic       rd_e, fs_e;
        @(posedge pixel_clock);
        #1;
        p++;
        h = h_of(p);
        v = v_of(p);
        if (h == 0 && v == 0) model_m64 = width_64;
        vram_data = pending;
        pending   = vram_rd ? mem[vram_addr] : 8'hEE;
        pix  = model_m64 ? h % 8 : h % 16;
        col  = model_m64 ? (h / 8) % 64 : (h / 16) % 32;
        row  = (v / c_RL) % 16;
        addr = (model_m64 ? row * 64 + col : row * 32 + col) % 1024;
        f    = flags_of(p);
        fd   = flags_of(p - c_PIX_DELAY);
        rd_e = f[3] && (pix == 1);
        fs_e = (h == 0) && (v == 0);
        if (!f[3]) exp_char = 8'h20;
        else if (pix >= 3) exp_char = mem[addr[9:0]];
        tests++;
        if ({vram_addr, vram_rd, char_code, subchar_line, subchar_pixel, text_active,
             de_out, border_out, hsync_n, vsync_n, frame_start} !==
            {addr[9:0], rd_e, exp_char, 5'(v % c_RL), 4'(pix), f[3],
             fd[3], fd[2], ~fd[1], ~fd[0], fs_e}) begin
            fails++;
            $display("FAIL cycle p=%0d h=%0d v=%0d: got addr=%0d rd=%0b char=%h line=%0d pix=%0d ta=%0b de=%0b bd=%0b hs_n=%0b vs_n=%0b fs=%0b; expected addr=%0d rd=%0b char=%h line=%0d pix=%0d ta=%0b de=%0b bd=%0b hs_n=%0b vs_n=%0b fs=%0b",
                     p, h, v, vram_addr, vram_rd, char_code, subchar_line, subchar_pixel, text_active,
                     de_out, border_out, hsync_n, vsync_n, frame_start,
                     addr, rd_e, exp_char, v % c_RL, pix, f[3], fd[3], fd[2], ~fd[1], ~fd[0], fs_e);
        end
        cnt_rd   += int'(vram_rd);
        cnt_de   += int'(de_out);
        cnt_hs   += int'(!hsync_n);
        cnt_vs   += int'(!vsync_n);
        cnt_pix3 += int'(subchar_pixel[3]);
    endtask

    task automatic run_to(input int target);
        while (p < target) step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i + 'h40);
        clear_counts();
        reset     = 1'b1;
        width_64  = 1'b0;
        vram_data = 8'hEE;
        #23 reset = 1'b0;
        run_to(1500);

        // asynchronous reset in the middle of a line
        #3 reset = 1'b1;
        #1;
        check("rst_hsync_n", 32'(hsync_n), 1);
        check("rst_vsync_n", 32'(vsync_n), 1);
        check("rst_vram_rd", 32'(vram_rd), 0);
        check("rst_char_code", 32'(char_code), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_de_out", 32'(de_out), 0);
        @(negedge pixel_clock);
        #2;
        p = -1; exp_char = 8'h00; model_m64 = 1'b0; pending = 8'hEE; vram_data = 8'hEE;
        reset = 1'b0;

        step();
        check("first_frame_start", 32'(frame_start), 1);
        step();
        check("first_rd", 32'(vram_rd), 1);
        check("first_addr", 32'(vram_addr), 0);
        step();
        check("char_before_fetch", 32'(char_code), 0);
        check("frame_start_one_clock", 32'(frame_start), 0);
        step();
        check("char_cell0", 32'(char_code), 32'h40);
        run_to(83);
        check("char_cell5", 32'(char_code), 32'h45);
        check("addr_cell5", 32'(vram_addr), 5);
        run_to(597);
        check("hsync_before_start", 32'(hsync_n), 1);
        step();
        check("hsync_start", 32'(hsync_n), 0);

        run_to(799);
        clear_counts();
        run_to(1599);
        check("rd_per_line_32", 32'(cnt_rd), 32);
        check("de_per_line", 32'(cnt_de), 512);
        check("hsync_width", 32'(cnt_hs), 96);

        run_to(15999);
        width_64 = 1'b1;
        run_to(19999);
        clear_counts();
        run_to(20799);
        check("rd_after_toggle_still_32", 32'(cnt_rd), 32);
        clear_counts();
        run_to(31999);
        check("vsync_width", 32'(cnt_vs), 1600);

        step();
        check("frame1_start", 32'(frame_start), 1);
        check("frame1_subline", 32'(subchar_line), 0);
        check("frame1_addr", 32'(vram_addr), 0);

        run_to(39999);
        clear_counts();
        step();
        step();
        check("row5_first_rd", 32'(vram_rd), 1);
        check("row5_first_addr", 32'(vram_addr), 320);
        run_to(40505);
        check("row5_last_rd", 32'(vram_rd), 1);
        check("row5_last_addr", 32'(vram_addr), 383);
        run_to(40799);
        check("rd_per_line_64", 32'(cnt_rd), 64);
        check("pix_bit3_low_64", 32'(cnt_pix3), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_video_sequencer.md
Name: text_video_sequencer

Overview:
Initiator for the character-generator interface. Generates horizontal and vertical raster timing on pixel_clock and fetches character codes from text video RAM. Drives char_code, subchar_line and subchar_pixel with the exact timing the character generator needs, and produces sync, blanking and border qualifiers for the SVGA output stage. Supports 32x16 and 64x16 text modes.

Parameters:
H_ACTIVE, 512, text-area pixel clocks per line
H_BORDER_R, 64, right border clocks
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
H_BORDER_L, 64, left border clocks (H total = 800)
ROW_LINES, 24, scan lines per text row (16 rows gives a 384-line text area)
V_BORDER_B, 48, bottom border lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
V_BORDER_T, 48, top border lines (V total = 525)
PIX_DELAY, 6, pixel_clock delay from counter to character-generator pixel output

Ports:
reset  in  1  asynchronous, active-high
pixel_clock  in  1  clock
width_64  in  1  1 = 64x16 text, 0 = 32x16; sampled at frame start only
vram_data  in  8  character code from video RAM; valid the clock after vram_rd
vram_addr  out  10  video RAM character address
vram_rd  out  1  read strobe, one clock per text cell
char_code  out  8  registered character code for the current cell
subchar_line  out  5  scan line within text row, 0..ROW_LINES-1
subchar_pixel  out  4  clock position within cell
text_active  out  1  current h/v position is inside the text area (undelayed)
de_out  out  1  text_active delayed by PIX_DELAY clocks, aligned to pixel_on
border_out  out  1  inside border region, delayed by PIX_DELAY clocks
hsync_n  out  1  active-low hsync, delayed by PIX_DELAY clocks
vsync_n  out  1  active-low vsync, delayed by PIX_DELAY clocks
frame_start  out  1  one-clock pulse at h=0, v=0

Behaviour:
- Reset (async, active-high): h_count=0, v_count=0, all outputs 0, except hsync_n=1 and vsync_n=1. Delay pipelines are cleared to the inactive state. The mode register is cleared to 0 (32-column mode).
- h_count runs 0..799 and wraps; v_count increments on each h wrap, runs 0..524 and wraps. Region order on each axis: text, far border, front porch, sync, back porch, near border.
- Horizontal regions: text 0..511; hsync active at h_count 592..687. Vertical regions: text 0..383; vsync active at v_count 442..443.
- Mode register m64 loads width_64 only on the clock where h_count=0 and v_count=0. A mid-frame change of width_64 has no effect until the next frame.
- subchar_pixel: h_count[3:0] when m64=0; {1'b0, h_count[2:0]} when m64=1. It counts freely across the whole line.
- Column: h_count[8:4], 0..31 (m64=0), or h_count[8:3], 0..63 (m64=1).
- Row: v_count / ROW_LINES, 0..15, kept as a row counter, not a divider. subchar_line is a 0..ROW_LINES-1 counter that advances on each h wrap.
- Row and subchar_line reset to 0 at v_count=0. Outside the text area they keep counting but have no meaning.
- vram_addr = row*32+col (m64=0) or row*64+col (m64=1); 10-bit, so row 15 col 63 gives address 1023.
- vram_rd pulses when subchar_pixel==1 inside the text area, with vram_addr stable. vram_data is registered into char_code at the end of the subchar_pixel==2 clock.
- char_code is therefore valid from subchar_pixel 3 and held through the end of the cell. This gives the character generator a stable code at its ROM access (pixel 4) and latch (pixel 5).
- Outside the text area: vram_rd=0 and char_code=8'h20.
- de_out, border_out, hsync_n and vsync_n come from a PIX_DELAY-stage shift register of the undelayed flags.
- frame_start is undelayed and is asserted for exactly one clock per frame.

Test Plan:
- Reset released at an arbitrary point -> h_count=0 and v_count=0; hsync_n=1, vsync_n=1, vram_rd=0, char_code=0 until the first fetch; first frame_start after 1 clock.
- Horizontal timing -> hsync_n low for exactly 96 clocks, starting PIX_DELAY+592 clocks after frame_start; line period 800 clocks; de_out high for 512 clocks per text line.
- 32-col fetch, line 0 -> vram_rd at h=1,17,33,...; vram_addr 0..31; vram_data=addr+8'h40 gives char_code=8'h40+n from h=16n+3; 32 pulses per line.
- 64-col fetch on text row 5 (v=120) -> vram_addr 320..383; vram_rd every 8 clocks; subchar_pixel[3]=0 throughout.
- width_64 toggled at v=200 -> no mode change until the next frame_start; then 64 fetches per line.
- Frame boundary -> after v=524, h=799: v_count, subchar_line and row all 0; frame_start pulses; vsync_n low for 1600 clocks per frame.
